// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_MIN_BAUD  = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/perif_uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
// o_overflow strobes for one cycle when a push is refused because the FIFO is full.
module perif_uart_rx_fifo #(
  parameter int unsigned p_depth_pw2 = 2,
  parameter int unsigned p_width     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [p_width-1:0] i_data,
  output logic [p_width-1:0] o_head,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow
);

  localparam int unsigned Depth = 2 ** p_depth_pw2;

  logic [p_depth_pw2:0] wr_q, rd_q;
  logic [p_width-1:0]   mem_q [Depth];
  logic                 do_push, do_pop;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[p_depth_pw2] != rd_q[p_depth_pw2]) &&
                   (wr_q[p_depth_pw2-1:0] == rd_q[p_depth_pw2-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop     = i_pop && !o_empty;
  assign do_push    = i_push && (!o_full || do_pop);
  assign o_overflow = i_push && o_full && !do_pop;

  // Head is forced to zero while empty so the bus never sees stale contents.
  assign o_head = o_empty ? '0 : mem_q[rd_q[p_depth_pw2-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q[p_depth_pw2-1:0]] <= i_data;
  end

endmodule

// File: rtl/perif_uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM and receive FIFO.
// Sticky framing/overflow flags are cleared by i_clr_err; a new error in the same cycle wins.
module perif_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned p_fifo_depth_pw2 = 2,
  parameter int unsigned p_sync_stages    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_baudrate,
  input  logic        i_uart_rx,
  input  logic        i_rd_en,
  input  logic        i_clr_err,
  output logic [7:0]  o_data_rx,
  output logic        o_rx_empty,
  output logic        o_rx_full,
  output logic        o_frame_err,
  output logic        o_overflow
);

  uart_rx_state_t            state_q, state_d;
  logic [p_sync_stages-1:0]  sync_q;
  logic                      rx_s, rx_prev_q;
  logic [15:0]               baud_eff, baud_q, cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      cnt_zero, start_det, sample, push, frame_set, fifo_ovf;
  logic                      frame_err_q, overflow_q;

  assign rx_s     = sync_q[p_sync_stages-1];
  assign baud_eff = (i_baudrate < 16'(UART_MIN_BAUD)) ? 16'(UART_MIN_BAUD) : i_baudrate;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[p_sync_stages-2:0], i_uart_rx};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_det) state_d = START;
      START:     if (sample) state_d = rx_s ? IDLE : DATA;
      DATA:      if (sample && bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
      STOP:      if (sample) state_d = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (!i_en) state_d = IDLE;
  end

  always_comb begin
    start_det = 1'b0;
    sample    = 1'b0;
    push      = 1'b0;
    frame_set = 1'b0;
    if (i_en) begin
      unique case (state_q)
        IDLE:        start_det = rx_prev_q & ~rx_s;
        START, DATA: sample    = cnt_zero;
        STOP: begin
          sample    = cnt_zero;
          push      = cnt_zero & rx_s;
          frame_set = cnt_zero & ~rx_s;
        end
        default: ;
      endcase
    end
  end

  // Baud is latched at start detection so mid-frame changes only affect the next frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      baud_q    <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else if (start_det) begin
      baud_q    <= baud_eff;
      cnt_q     <= baud_eff >> 1;
      bit_idx_q <= '0;
    end else if (sample) begin
      cnt_q <= baud_q - 16'd1;
      if (state_q == DATA) begin
        shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
    end else if (!cnt_zero) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (frame_set)      frame_err_q <= 1'b1;
      else if (i_clr_err) frame_err_q <= 1'b0;
      if (fifo_ovf)       overflow_q  <= 1'b1;
      else if (i_clr_err) overflow_q  <= 1'b0;
    end
  end

  perif_uart_rx_fifo #(
    .p_depth_pw2(p_fifo_depth_pw2),
    .p_width    (UART_DATA_BITS)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (push),
    .i_pop     (i_rd_en),
    .i_data    (shift_q),
    .o_head    (o_data_rx),
    .o_empty   (o_rx_empty),
    .o_full    (o_rx_full),
    .o_overflow(fifo_ovf)
  );

  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule
